// File: rtl/uart_txrx.sv
// uart_txrx: 8N1 UART transceiver. The transmit and receive halves run
// independently and share only the clock and reset.
//
// Ports:
//   clk           rising-edge clock for all logic
//   rst           asynchronous active-high reset
//   tx_data[7:0]  byte to send, latched when a frame is accepted
//   tx_start      request to transmit; ignored while a frame is in flight
//   tx_out        serial line out (idles high)
//   tx_busy       high while a frame is being sent
//   rx_in         serial line in, asynchronous to clk
//   rx_data[7:0]  last correctly received byte
//   rx_valid      one-cycle pulse when rx_data updates
//   rx_frame_err  one-cycle pulse when a frame ends with a low stop bit
//
// State table (shared by both halves)
//   state   | meaning
//   S_IDLE  | line idle, waiting for tx_start / falling start edge
//   S_START | start bit (TX drives 0; RX waits to bit centre)
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (TX drives 1; RX checks for 1)
module uart_txrx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_out,
    output logic       tx_busy,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_TOP  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TOP = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
    logic [2:0]      tx_idx_q,   tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_out_q,   tx_out_d;
    logic            tx_busy_q,  tx_busy_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_busy_d  = tx_busy_q;
        if (tx_state_q != S_IDLE && tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end
        case (tx_state_q)
            S_IDLE: begin
                tx_out_d  = 1'b1;
                tx_busy_d = 1'b0;
                if (tx_start) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = BIT_TOP;
                    tx_shift_d = tx_data;
                    tx_out_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = BIT_TOP;
                    tx_idx_d   = 3'd0;
                    tx_out_d   = tx_shift_q[0];
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_TOP;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_out_d = tx_shift_q[tx_idx_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    // A request on the final stop cycle starts the next
                    // frame with no idle bit in between.
                    if (tx_start) begin
                        tx_state_d = S_START;
                        tx_cnt_d   = BIT_TOP;
                        tx_shift_d = tx_data;
                        tx_out_d   = 1'b0;
                    end else begin
                        tx_state_d = S_IDLE;
                        tx_out_d   = 1'b1;
                        tx_busy_d  = 1'b0;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_out_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;

    // ---------------- receiver ----------------
    logic [1:0]      rx_sync_q,  rx_sync_d;
    state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [2:0]      rx_idx_q,   rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q,  rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q,   rx_err_d;
    logic            rx_line;

    assign rx_sync_d = {rx_sync_q[0], rx_in};
    assign rx_line   = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (rx_state_q != S_IDLE && rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_line) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = HALF_TOP;
                end
            end
            S_START: begin
                // Half a bit in: a high line here was a glitch, not a start.
                if (rx_cnt_q == '0) begin
                    if (rx_line) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_cnt_d   = BIT_TOP;
                        rx_idx_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_TOP;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (rx_line) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_uart_txrx.sv
module tb_uart_txrx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_out;
    logic       tx_busy;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    assign rx_in = loop_en ? tx_out : rx_drv;

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_out       (tx_out),
        .tx_busy      (tx_busy),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_events = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t exp_q[$];
    rx_exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every RX pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_frame_err)) begin
            n_events++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got valid=%0b err=%0b data=0x%0h want no event",
                         rx_valid, rx_frame_err, rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_err_flag", {31'b0, rx_frame_err}, {31'b0, mon_e.err});
                check("rx_valid_flag", {31'b0, rx_valid}, {31'b0, !mon_e.err});
                check("rx_data", {24'b0, rx_data}, {24'b0, mon_e.data});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just after the acceptance edge.
    task automatic send_tx(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(CPB);
        end
        rx_drv = stop_bit;
        tick(CPB);
        rx_drv = 1'b1;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        int mis;
        int busy_cnt;
        int ev0;

        // ---- reset ----
        rst    = 1'b1;
        rx_drv = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_out", {31'b0, tx_out}, 1);
        check("rst_tx_busy", {31'b0, tx_busy}, 0);
        check("rst_rx_data", {24'b0, rx_data}, 0);
        check("rst_rx_valid", {31'b0, rx_valid}, 0);
        check("rst_rx_frame_err", {31'b0, rx_frame_err}, 0);
        rst = 1'b0;
        tick(2);

        // ---- TX waveform for 0x5D ----
        frame    = {1'b1, 8'h5D, 1'b0};
        busy_cnt = 0;
        send_tx(8'h5D);
        for (int b = 0; b < 10; b++) begin
            mis = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx_out !== frame[b]) mis++;
                if (tx_busy === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            check($sformatf("tx_bit%0d_bad_cycles", b), mis, 0);
        end
        check("tx_busy_cycles", busy_cnt, 160);
        check("tx_busy_after_frame", {31'b0, tx_busy}, 0);
        check("tx_out_after_frame", {31'b0, tx_out}, 1);

        // ---- loopback, back-to-back 0x5D then 0xA2 ----
        tick(5);
        loop_en = 1'b1;
        ev0 = n_events;
        exp_q.push_back('{err: 1'b0, data: 8'h5D});
        exp_q.push_back('{err: 1'b0, data: 8'hA2});
        send_tx(8'h5D);
        tick(159);
        send_tx(8'hA2);
        check("b2b_busy_held", {31'b0, tx_busy}, 1);
        check("b2b_start_bit", {31'b0, tx_out}, 0);
        drain("loopback_drain", 400);
        tick(2 * CPB);
        check("loopback_events", n_events - ev0, 2);
        loop_en = 1'b0;
        tick(4);

        // ---- false start ----
        ev0 = n_events;
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(3 * CPB);
        check("false_start_events", n_events - ev0, 0);

        // ---- good frame driven directly, then framing error ----
        exp_q.push_back('{err: 1'b0, data: 8'hC4});
        drive_frame(8'hC4, 1'b1);
        drain("direct_frame_drain", 100);
        tick(CPB);
        ev0 = n_events;
        exp_q.push_back('{err: 1'b1, data: 8'hC4});
        drive_frame(8'h33, 1'b0);
        tick(2 * CPB);
        drain("frame_err_drain", 100);
        check("frame_err_events", n_events - ev0, 1);
        check("frame_err_data_kept", {24'b0, rx_data}, 32'hC4);

        // ---- busy request ignored ----
        loop_en = 1'b1;
        tick(4);
        ev0 = n_events;
        exp_q.push_back('{err: 1'b0, data: 8'h5D});
        send_tx(8'h5D);
        tick(40);
        send_tx(8'hFF);
        tx_data = 8'h00;
        tick(118);
        check("busy_ignore_busy_late", {31'b0, tx_busy}, 1);
        tick(1);
        check("busy_ignore_busy_fell", {31'b0, tx_busy}, 0);
        check("busy_ignore_idle_line", {31'b0, tx_out}, 1);
        drain("busy_ignore_drain", 100);
        tick(200);
        check("busy_ignore_events", n_events - ev0, 1);

        // ---- reset mid-frame ----
        ev0 = n_events;
        send_tx(8'h5D);
        tick(50);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_out", {31'b0, tx_out}, 1);
        check("midrst_tx_busy", {31'b0, tx_busy}, 0);
        check("midrst_rx_data", {24'b0, rx_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(12 * CPB);
        check("midrst_events", n_events - ev0, 0);

        // ---- clean frame after reset ----
        exp_q.push_back('{err: 1'b0, data: 8'h3C});
        send_tx(8'h3C);
        drain("post_rst_drain", 300);
        tick(CPB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
